// File: rtl/hazard_forward_unit_if.sv
// ID-stage hazard/forwarding bundle.
// master drives ID fields and Flush; slave returns Stall, SelA/SelB, StallCount.
interface hazard_forward_unit_if;
  logic [4:0]  Rs_ID;
  logic [4:0]  Rt_ID;
  logic [4:0]  Rd_ID;
  logic        UsesRs_ID;
  logic        UsesRt_ID;
  logic        RegWrite_ID;
  logic        MemRead_ID;
  logic        Flush;
  logic [1:0]  SelA;
  logic [1:0]  SelB;
  logic        Stall;
  logic [15:0] StallCount;

  modport master (
    output Rs_ID,
    output Rt_ID,
    output Rd_ID,
    output UsesRs_ID,
    output UsesRt_ID,
    output RegWrite_ID,
    output MemRead_ID,
    output Flush,
    input  SelA,
    input  SelB,
    input  Stall,
    input  StallCount
  );

  modport slave (
    input  Rs_ID,
    input  Rt_ID,
    input  Rd_ID,
    input  UsesRs_ID,
    input  UsesRt_ID,
    input  RegWrite_ID,
    input  MemRead_ID,
    input  Flush,
    output SelA,
    output SelB,
    output Stall,
    output StallCount
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Load-use stall + operand forwarding select unit.
// Ports: Clk, Rst_n (async low), hz (slave: ID fields in, Stall/Sel*/StallCount out).
module hazard_forward_unit (
  input  logic             Clk,
  input  logic             Rst_n,
  hazard_forward_unit_if.slave hz
);

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic [4:0] rd;
  } trk_t;

  localparam trk_t BUBBLE = '0;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;
  localparam logic [1:0] SEL_WBD = 2'b11;

  trk_t ex_q, ex_d;
  trk_t mem_q;
  trk_t wb_q;
  trk_t wb2_q;

  logic [1:0]  sel_a_q, sel_a_d;
  logic [1:0]  sel_b_q, sel_b_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic stall;
  logic bubble;
  logic lu_rs;
  logic lu_rt;

  function automatic logic cand(trk_t e);
    return e.v & e.rw & (e.rd != 5'd0);
  endfunction

  function automatic logic hit(trk_t e, logic [4:0] r);
    return cand(e) & (e.rd == r);
  endfunction

  // Bubbles always carry all-zero fields.
  function automatic logic clean(trk_t e);
    return e.v | (e == BUBBLE);
  endfunction

  // Nearest producing stage wins.
  function automatic logic [1:0] pick(
    logic       uses,
    logic [4:0] r,
    trk_t       ex,
    trk_t       mem,
    trk_t       wb
  );
    logic       hx;
    logic       hm;
    logic       hw;
    logic [1:0] s;
    s  = SEL_RF;
    hx = uses & (r != 5'd0) & hit(ex, r);
    hm = uses & (r != 5'd0) & hit(mem, r) & ~hx;
    hw = uses & (r != 5'd0) & hit(wb, r) & ~hx & ~hm;
    unique case (1'b1)
      hx:      s = SEL_EXM;
      hm:      s = SEL_MWB;
      hw:      s = SEL_WBD;
      default: s = SEL_RF;
    endcase
    return s;
  endfunction

  always_comb begin
    lu_rs = hz.UsesRs_ID & (hz.Rs_ID == ex_q.rd);
    lu_rt = hz.UsesRt_ID & (hz.Rt_ID == ex_q.rd);
    stall = ~hz.Flush & cand(ex_q) & ex_q.mr
          & (lu_rs | lu_rt);
    bubble = stall | hz.Flush;
  end

  always_comb begin
    ex_d    = BUBBLE;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (!bubble) begin
      ex_d.v  = 1'b1;
      ex_d.rw = hz.RegWrite_ID;
      ex_d.mr = hz.MemRead_ID;
      ex_d.rd = hz.Rd_ID;
      sel_a_d = pick(hz.UsesRs_ID, hz.Rs_ID,
                     ex_q, mem_q, wb_q);
      sel_b_d = pick(hz.UsesRt_ID, hz.Rt_ID,
                     ex_q, mem_q, wb_q);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      wb_q        <= BUBBLE;
      wb2_q       <= BUBBLE;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
      stall_cnt_q <= '0;
    end else begin
      wb2_q       <= wb_q;
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      assert (clean(ex_q) && clean(mem_q)
              && clean(wb_q) && clean(wb2_q));
    end
  end

  assign hz.Stall      = stall;
  assign hz.SelA       = sel_a_q;
  assign hz.SelB       = sel_b_q;
  assign hz.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: pipeline-history model
// checked every negedge, plus directed literal checks.
module tb_hazard_forward_unit;

  logic Clk = 1'b0;
  logic Rst_n;

  hazard_forward_unit_if hz ();

  hazard_forward_unit dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .hz    (hz.slave)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Model: the instructions that occupy EX, MEM, WB, WB2.
  typedef struct {
    bit v;
    bit rw;
    bit mr;
    int rd;
  } ins_t;

  ins_t pipe [4];
  int   n_st     = 0;
  int   cnt_base = 0;
  int   m_sa     = 0;
  int   m_sb     = 0;

  function automatic bit live(ins_t e);
    return e.v && e.rw && (e.rd != 0);
  endfunction

  function automatic int src_sel(bit uses, int r);
    if (!uses || r == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (live(pipe[i]) && pipe[i].rd == r) return i + 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    if (hz.Flush) return 0;
    if (!(live(pipe[0]) && pipe[0].mr)) return 0;
    return (hz.UsesRs_ID && int'(hz.Rs_ID) == pipe[0].rd)
        || (hz.UsesRt_ID && int'(hz.Rt_ID) == pipe[0].rd);
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    bit   st;
    ins_t nw;
    if (!Rst_n) begin
      for (int i = 0; i < 4; i++) pipe[i] <= '{0, 0, 0, 0};
      n_st <= 0;
      m_sa <= 0;
      m_sb <= 0;
    end else begin
      st = m_stall();
      if (st) n_st <= n_st + 1;
      if (st || hz.Flush) begin
        nw = '{0, 0, 0, 0};
        m_sa <= 0;
        m_sb <= 0;
      end else begin
        nw = '{1'b1, hz.RegWrite_ID, hz.MemRead_ID, int'(hz.Rd_ID)};
        m_sa <= src_sel(hz.UsesRs_ID, int'(hz.Rs_ID));
        m_sb <= src_sel(hz.UsesRt_ID, int'(hz.Rt_ID));
      end
      for (int i = 3; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= nw;
    end
  end

  always @(negedge Clk) begin
    int ec;
    ec = cnt_base + n_st;
    if (ec > 65535) ec = 65535;
    chk("m_stall", int'(hz.Stall), int'(m_stall()));
    chk("m_selA", int'(hz.SelA), m_sa);
    chk("m_selB", int'(hz.SelB), m_sb);
    chk("m_cnt", int'(hz.StallCount), ec);
  end

  task automatic drive(int rs, bit ur, int rt, bit ut,
                       int rd, bit rw, bit mr, bit fl);
    hz.Rs_ID       = 5'(rs);
    hz.UsesRs_ID   = ur;
    hz.Rt_ID       = 5'(rt);
    hz.UsesRt_ID   = ut;
    hz.Rd_ID       = 5'(rd);
    hz.RegWrite_ID = rw;
    hz.MemRead_ID  = mr;
    hz.Flush       = fl;
  endtask

  bit st;

  task automatic step(int rs, bit ur, int rt, bit ut,
                      int rd, bit rw, bit mr, bit fl);
    drive(rs, ur, rt, ut, rd, rw, mr, fl);
    #1 st = hz.Stall;
    @(posedge Clk);
    #1;
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    Rst_n = 1'b0;
    drive(8, 1, 8, 1, 9, 1, 1, 0);
    @(posedge Clk);
    #1;
    chk("rst_stall", int'(hz.Stall), 0);
    chk("rst_selA", int'(hz.SelA), 0);
    chk("rst_cnt", int'(hz.StallCount), 0);
    Rst_n = 1'b1;

    // first cycle after release: EX is a bubble
    step(8, 1, 8, 1, 9, 1, 1, 0);
    chk("post_rst_stall", int'(st), 0);
    nops(3);

    // ALU r5 then reader of r5
    step(0, 0, 0, 0, 5, 1, 0, 0);
    step(5, 1, 6, 1, 7, 1, 0, 0);
    chk("alu_stall", int'(st), 0);
    chk("alu_selA", int'(hz.SelA), 1);
    chk("alu_selB", int'(hz.SelB), 0);
    nops(3);

    // lw r8 then reader of Rt=r8
    step(0, 0, 0, 0, 8, 1, 1, 0);
    step(1, 1, 8, 1, 9, 1, 0, 0);
    chk("lu_stall", int'(st), 1);
    chk("lu_bubble_selB", int'(hz.SelB), 0);
    chk("lu_cnt1", int'(hz.StallCount), 1);
    step(1, 1, 8, 1, 9, 1, 0, 0);
    chk("lu_stall2", int'(st), 0);
    chk("lu_selB", int'(hz.SelB), 2);
    chk("lu_cnt", int'(hz.StallCount), 1);
    nops(3);

    // r3 written in EX, MEM and WB
    repeat (3) step(0, 0, 0, 0, 3, 1, 0, 0);
    step(3, 1, 0, 0, 0, 0, 0, 0);
    chk("near_selA", int'(hz.SelA), 1);
    step(0, 0, 0, 0, 3, 1, 0, 0);
    nops(2);
    step(3, 1, 0, 0, 0, 0, 0, 0);
    chk("wb_selA", int'(hz.SelA), 3);
    step(0, 0, 0, 0, 3, 1, 0, 0);
    nops(1);
    step(3, 1, 0, 0, 0, 0, 0, 0);
    chk("mem_selA", int'(hz.SelA), 2);
    nops(3);

    // r0 never forwards or stalls
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 4, 1, 0, 0);
    chk("r0_stall", int'(st), 0);
    chk("r0_selA", int'(hz.SelA), 0);
    chk("r0_selB", int'(hz.SelB), 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    chk("r0_load_stall", int'(st), 0);

    // unused source never forwards
    step(0, 0, 0, 0, 4, 1, 0, 0);
    step(4, 0, 4, 1, 0, 0, 0, 0);
    chk("nouse_selA", int'(hz.SelA), 0);
    chk("use_selB", int'(hz.SelB), 1);
    nops(3);

    // load-use coinciding with Flush
    step(0, 0, 0, 0, 8, 1, 1, 0);
    step(0, 0, 8, 1, 9, 1, 0, 1);
    chk("fl_stall", int'(st), 0);
    chk("fl_selB", int'(hz.SelB), 0);
    chk("fl_cnt", int'(hz.StallCount), 1);
    step(8, 1, 0, 0, 0, 0, 0, 0);
    chk("fl_ex_bubble_stall", int'(st), 0);
    chk("fl_mem_selA", int'(hz.SelA), 2);
    nops(3);

    // async reset in the middle of a stall
    step(0, 0, 0, 0, 11, 1, 0, 0);
    step(11, 1, 0, 0, 10, 1, 1, 0);
    drive(10, 1, 0, 0, 12, 1, 0, 0);
    #1;
    chk("mid_stall", int'(hz.Stall), 1);
    chk("mid_selA", int'(hz.SelA), 1);
    chk("mid_cnt", int'(hz.StallCount), 1);
    @(negedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    chk("arst_stall", int'(hz.Stall), 0);
    chk("arst_selA", int'(hz.SelA), 0);
    chk("arst_cnt", int'(hz.StallCount), 0);
    #1 Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("arst_after_selA", int'(hz.SelA), 0);
    chk("arst_after_cnt", int'(hz.StallCount), 0);
    nops(3);

    // saturation: start near the top of the counter
    force dut.stall_cnt_q = 16'hFFFC;
    cnt_base = 'hFFFC - n_st;
    #1 release dut.stall_cnt_q;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0, 8, 1, 1, 0);
      step(0, 0, 8, 1, 9, 1, 0, 0);
      step(0, 0, 8, 1, 9, 1, 0, 0);
      chk("sat_cnt", int'(hz.StallCount),
          (k < 3) ? 'hFFFD + k : 'hFFFF);
    end

    nops(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 Rst_n  input  1  asynchronous, active-low reset.
REQ-003 Rs_ID, Rt_ID  input  5 each  source register numbers of the instruction in ID.
REQ-004 UsesRs_ID, UsesRt_ID  input  1 each  ID instruction reads Rs / Rt.
REQ-005 Rd_ID  input  5  destination register of the ID instruction.
REQ-006 RegWrite_ID, MemRead_ID  input  1 each  ID instruction writes a register / is a load.
REQ-007 Flush  input  1  branch/jump taken; kill the ID instruction.
REQ-008 SelA, SelB  output  2 each  registered selects for the EX-stage operand muxes: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 write-back-delayed result.
REQ-009 Stall  output  1  combinational; hold PC and IF/ID, insert bubble.
REQ-010 StallCount  output  16  saturating count of stall cycles since reset.

Function
REQ-011 Unit SHALL keep four tracking entries, EX, MEM, WB, WB2, each holding {valid, regwrite, memread, rd[4:0]}.
REQ-012 Each rising edge SHALL shift: WB2<=WB, WB<=MEM, MEM<=EX, unconditionally.
REQ-013 EX entry SHALL load {1, RegWrite_ID, MemRead_ID, Rd_ID} when Stall=0 and Flush=0; otherwise load bubble (all fields 0).
REQ-014 An entry SHALL be a forwarding candidate only if valid=1, regwrite=1, rd!=0.
REQ-015 Stall SHALL be 1 when Flush=0 and the EX entry is a candidate with memread=1 and rd equals Rs_ID (with UsesRs_ID=1) or Rt_ID (with UsesRt_ID=1); else 0.
REQ-016 Stall SHALL be a pure function of current EX entry and ID inputs; no additional latency.
REQ-017 When Stall=0 and Flush=0, SelA SHALL load at the edge: 01 if EX entry candidate matches Rs_ID, else 10 if MEM entry matches, else 11 if WB entry matches, else 00; nearest stage wins.
REQ-018 SelB SHALL be computed identically using Rt_ID.
REQ-019 Sel SHALL be 00 for a source when its Uses* input is 0 or the register number is 0.
REQ-020 When Stall=1 or Flush=1, SelA and SelB SHALL load 00 (bubble in EX).
REQ-021 Flush SHALL take priority over Stall; Stall output SHALL be 0 while Flush=1.
REQ-022 Sel values are valid in the cycle the instruction occupies EX, one cycle after it was in ID.
REQ-023 StallCount SHALL increment by 1 on each edge where Stall=1 and SHALL hold at 16'hFFFF once reached.
REQ-024 A load followed by a dependent instruction SHALL produce exactly one stall cycle; after the bubble the dependent instruction SHALL receive Sel=10.

Reset
REQ-025 Rst_n=0 SHALL immediately, without waiting for a clock edge, clear all four tracking entries to bubble, SelA=SelB=00, StallCount=0.
REQ-026 Stall SHALL read 0 during reset and in the first cycle after release, because the EX entry is a bubble.
REQ-027 Reset asserted mid-stall SHALL discard the stall; no partial state SHALL survive deassertion.

Verification
REQ-028 ALU write r5, then a dependent instruction reads Rs=r5 in the next cycle -> SelA=01 in its EX cycle, Stall=0.
REQ-029 lw r8, then an instruction reading Rt=r8 in the next cycle -> Stall=1 for one cycle, SelB=00 (bubble), then SelB=10 for the dependent instruction, StallCount=1.
REQ-030 Writes to r3 in EX, MEM and WB simultaneously while ID reads Rs=r3 -> SelA=01 (nearest wins). With only the WB write present -> SelA=11.
REQ-031 Write to r0 with RegWrite=1, then ID reads r0 -> SelA=SelB=00, Stall=0. A load to r0 causes no stall.
REQ-032 Load-use condition with Flush=1 in the same cycle -> Stall=0, Sel=00, EX entry bubble, StallCount unchanged.
REQ-033 Rst_n pulsed low between clock edges during a stall -> outputs clear asynchronously. 65540 forced stalls -> StallCount=16'hFFFF.
